// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Shared constants and types for the multiplier / product accumulator path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int PROD_W     = 64;
  localparam int DEF_ACC_W  = 64;

  // Saturation limits for the default accumulator width.
  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_add.sv
// ============================================================================
// Module : sat_add
// Combinational signed saturating adder; sat flags a clamped result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_add #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  localparam logic [W-1:0] C_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] w_full;

  // One guard bit: the top two bits disagree exactly when the true sum is out of range.
  assign w_full = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    sum = w_full[W-1:0];
    sat = 1'b0;
    if (w_full[W] != w_full[W-1]) begin
      sat = 1'b1;
      sum = w_full[W] ? C_MIN : C_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module : product_accumulator
// Sums a programmed number of signed products into a saturating accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = mult_pkg::DEF_ACC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow,
  output logic              busy
);

  import mult_pkg::*;

  acc_state_t        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_len;
  logic              r_overflow;

  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_sat;
  logic              w_last;

  generate
    if (ACC_W > PROD_W) begin : g_sext_wide
      assign w_prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end else begin : g_sext_equal
      assign w_prod_ext = product[ACC_W-1:0];
    end
  endgenerate

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (r_acc),
    .b   (w_prod_ext),
    .sum (w_sum),
    .sat (w_sat)
  );

  assign w_last = ((r_count + CNT_W'(1)) == r_len);

  // Handshake outputs come straight from the state register: no input-to-output path.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign acc       = r_acc;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_len      <= len;
            r_state    <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_acc      <= w_sum;
            r_overflow <= r_overflow | w_sat;
            r_count    <= r_count + CNT_W'(1);
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module : tb_product_accumulator
// Self-checking bench: directed table, corner sequences, randomized vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam logic signed [63:0] MAXV = 64'sh7fff_ffff_ffff_ffff;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;
  localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;

  typedef logic signed [63:0] prod_arr_t [8];

  typedef struct {
    string             name;
    int                n;
    prod_arr_t         p;
    logic signed [63:0] exp_acc;
    logic              exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] product = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] acc;
  logic        overflow;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Stand-in for the upstream 32x32 signed multiplier.
  function automatic logic signed [63:0] mul32(input int x, input int y);
    return 64'(longint'(x) * longint'(y));
  endfunction

  // Reference: exact running sum with clamping after each term.
  task automatic model(input int n, input prod_arr_t p,
                       output logic signed [63:0] a, output logic o);
    logic signed [65:0] s;
    s = '0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + 66'(p[i]);
      if (s > 66'(MAXV)) begin s = 66'(MAXV); o = 1'b1; end
      if (s < 66'(MINV)) begin s = 66'(MINV); o = 1'b1; end
    end
    a = s[63:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full sequence; returns the result seen in DONE and finishes the handshake.
  task automatic run_seq(input string tag, input int n, input prod_arr_t p,
                         input int gap_max, input int hold, input bit poke_start,
                         output logic [63:0] a_o, output logic o_o);
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    len   = 16'hffff;
    if (n == 0) begin
      check({tag, " len0 out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " len0 in_ready"}, 64'(in_ready), 64'd0);
    end else begin
      check({tag, " in_ready after start"}, 64'(in_ready), 64'd1);
    end
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int k = 0; k < g; k++) tick();
      in_valid = 1'b1;
      product  = p[i];
      tick();
      in_valid = 1'b0;
      product  = 64'hdead_beef_dead_beef;
      if (i < n - 1 && out_valid) check({tag, " early out_valid"}, 64'(out_valid), 64'd0);
    end
    check({tag, " out_valid after last beat"}, 64'(out_valid), 64'd1);
    a_o = acc;
    o_o = overflow;
    for (int k = 0; k < hold; k++) begin
      if (poke_start && k == 1) begin start = 1'b1; len = 16'd3; end
      tick();
      start = 1'b0;
      if (k == hold - 1) begin
        check({tag, " held out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " held acc"}, acc, a_o);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle after handshake"}, {62'd0, out_valid, busy}, 64'd0);
  endtask

  vec_t             vecs[6];
  logic [63:0]      a_got;
  logic             o_got;
  logic signed [63:0] e_acc;
  logic             e_ovf;
  prod_arr_t        pz;

  initial begin
    for (int i = 0; i < 8; i++) pz[i] = '0;
    vecs[0] = '{"sum3",    3, pz, 64'sd96, 1'b0};
    vecs[0].p[0] = 6; vecs[0].p[1] = -10; vecs[0].p[2] = 100;
    vecs[1] = '{"mulfed",  2, pz, -64'sd246975, 1'b0};
    vecs[1].p[0] = mul32(-7, 9); vecs[1].p[1] = mul32(123456, -2);
    vecs[2] = '{"len0",    0, pz, 64'sd0, 1'b0};
    vecs[3] = '{"satpos",  2, pz, MAXV, 1'b1};
    vecs[3].p[0] = P62; vecs[3].p[1] = P62;
    vecs[4] = '{"exactmin",3, pz, MINV + 64'sd5, 1'b0};
    vecs[4].p[0] = -P62; vecs[4].p[1] = -P62; vecs[4].p[2] = 5;
    vecs[5] = '{"satneg",  4, pz, MINV + 64'sd5, 1'b1};
    vecs[5].p[0] = -P62; vecs[5].p[1] = -P62; vecs[5].p[2] = -1; vecs[5].p[3] = 5;

    #3;
    check("reset acc", acc, 64'd0);
    check("reset flags", {59'd0, in_ready, out_valid, busy, overflow, 1'b0}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].name, vecs[v].n, vecs[v].p, 0, 0, 1'b0, a_got, o_got);
      check({vecs[v].name, " acc"}, a_got, vecs[v].exp_acc);
      check({vecs[v].name, " overflow"}, 64'(o_got), 64'(vecs[v].exp_ovf));
    end

    // Overflow from the last sequence stays visible in IDLE; the next start clears it.
    check("sticky ovf in idle", 64'(overflow), 64'd1);

    // Back-pressure with input gaps, out_ready low 5 cycles, start poked during DONE.
    pz[0] = 64'sd11; pz[1] = -64'sd4; pz[2] = 64'sd1000;
    run_seq("bp", 3, pz, 3, 5, 1'b1, a_got, o_got);
    check("bp acc", a_got, 64'd1007);
    check("bp ovf cleared", 64'(o_got), 64'd0);

    // Reset mid-ACCUM after 2 of 4 beats.
    start = 1'b1; len = 16'd4; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; product = 64'd77; tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst acc", acc, 64'd0);
    check("rst flags", {60'd0, in_ready, out_valid, busy, overflow}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    pz[0] = 64'sd42;
    run_seq("post rst", 1, pz, 0, 0, 1'b0, a_got, o_got);
    check("post rst acc", a_got, 64'd42);

    // Randomized sequences against the reference model.
    for (int t = 0; t < 40; t++) begin
      prod_arr_t rp;
      int        n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 2))
          0:       rp[i] = 64'($signed($urandom_range(0, 2000))) - 64'sd1000;
          1:       rp[i] = {$urandom, $urandom};
          default: rp[i] = ($urandom_range(0, 1) == 1) ? P62 + 64'($urandom_range(0, 9))
                                                       : -P62 - 64'($urandom_range(0, 9));
        endcase
      end
      model(n, rp, e_acc, e_ovf);
      run_seq($sformatf("rnd%0d", t), n, rp, $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), a_got, o_got);
      check($sformatf("rnd%0d acc", t), a_got, e_acc);
      check($sformatf("rnd%0d ovf", t), 64'(o_got), 64'(e_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
